// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the pipelined ALU: opcode
//                encoding, control state encoding and the illegal-opcode
//                result pattern (all ones across the 2*WIDTH result).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Widest result the illegal-pattern helper can build (supports WIDTH <= 64).
    localparam int unsigned c_max_result_w = 128;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_MUL  = 3'b101,
        OP_XNOR = 3'b110,
        OP_ILL  = 3'b111
    } alu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alu_state_e;

    // All-ones pattern over the low 2*width bits; callers slice the
    // 2*WIDTH bits they need.
    function automatic logic [c_max_result_w-1:0] alu_illegal_result(input int unsigned width);
        logic [c_max_result_w-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < c_max_result_w; i++) begin
            if (i < 2 * width) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_seq_mul.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_mul
//  Description : Iterative unsigned shift-add multiplier. A start pulse
//                captures the operands; one partial product is accumulated
//                per cycle for WIDTH cycles. done pulses combinationally on
//                the last iteration with the final product on product, so
//                the caller registers the result on that same edge.
//                Only instantiated when ALU_MUL_EN is defined.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                start           - capture a/b and begin iterating
//                a, b            - WIDTH-bit unsigned operands
//                done            - last-iteration strobe
//                product         - 2*WIDTH-bit product, valid with done
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    logic                 r_busy;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_mcand;   // multiplicand, shifted left each step
    logic [WIDTH-1:0]     r_mplier;  // multiplier, shifted right each step
    logic [2*WIDTH-1:0]   r_acc;

    logic [2*WIDTH-1:0]   w_partial;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_partial  = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_partial;

    // Exposing the next accumulator value lets the product land in the
    // output register on the final iteration edge without an extra cycle.
    assign done    = r_busy && (r_cnt == c_last);
    assign product = w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            if (done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule : alu_seq_mul
`default_nettype wire

// File: rtl/pipelined_alu.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_alu
//  Description : Parametrised ALU with valid/ready input and output
//                handshakes. Logic and add/subtract ops complete in one
//                cycle; MUL runs on the iterative alu_seq_mul over WIDTH
//                cycles. Result and flags are held under back-pressure.
//  Config      : ALU_MUL_EN - when defined, the multiplier and BUSY state
//                are built in. When undefined, MUL (101) behaves exactly
//                like the illegal opcode (all-ones result, err=1).
//  Ports       : clk, rst              - clock, sync active-high reset
//                in_valid / in_ready   - operand handshake
//                a, b, opcode          - WIDTH-bit operands, 3-bit op
//                out_valid / out_ready - result handshake
//                result                - 2*WIDTH-bit result
//                zero, carry, ovf, err - status flags (with out_valid)
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8     // operand width, >= 2 and <= 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero,
    output logic                 carry,
    output logic                 ovf,
    output logic                 err
);

    localparam logic [c_max_result_w-1:0] c_illegal_full = alu_illegal_result(WIDTH);
    localparam logic [2*WIDTH-1:0]        c_illegal      = c_illegal_full[2*WIDTH-1:0];

    alu_state_e           r_state;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_zero;
    logic                 r_carry;
    logic                 r_ovf;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_is_mul;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_mul_product;

    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0]   w_res;
    logic                 w_carry;
    logic                 w_ovf;
    logic                 w_err;
    logic                 w_zero;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign in_ready = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Optional iterative multiplier
    // ------------------------------------------------------------------
`ifdef ALU_MUL_EN
    assign w_is_mul = (opcode == OP_MUL);

    alu_seq_mul #(
        .WIDTH   (WIDTH)
    ) u_seq_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_accept && w_is_mul),
        .a       (a),
        .b       (b),
        .done    (w_mul_done),
        .product (w_mul_product)
    );
`else
    // MUL decodes as illegal in the single-cycle path below.
    assign w_is_mul      = 1'b0;
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;
`endif

    // ------------------------------------------------------------------
    // Single-cycle operations
    // ------------------------------------------------------------------
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_res   = {{(WIDTH-1){1'b0}}, w_sum};
                w_carry = w_sum[WIDTH];
                // Like-signed operands with a differently-signed sum.
                w_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = w_diff;
                w_carry = (a < b);
                // Unlike-signed operands with the result sign flipped from a.
                w_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  w_res = {{WIDTH{1'b0}}, a & b};
            OP_OR:   w_res = {{WIDTH{1'b0}}, a | b};
            OP_XOR:  w_res = {{WIDTH{1'b0}}, a ^ b};
            OP_XNOR: w_res = {{WIDTH{1'b0}}, ~(a ^ b)};
            default: begin
                // Illegal opcode, and MUL when the multiplier is not built.
                w_res = c_illegal;
                w_err = 1'b1;
            end
        endcase
    end

    assign w_zero = !w_err && (w_res == '0);

    // ------------------------------------------------------------------
    // Control state and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_mul_done) begin
                r_state     <= ST_IDLE;
                r_out_valid <= 1'b1;
                r_result    <= w_mul_product;
                r_zero      <= (w_mul_product == '0);
                r_carry     <= 1'b0;
                r_ovf       <= 1'b0;
                r_err       <= 1'b0;
            end else if (w_accept && w_is_mul) begin
                // Any previous result drains on this edge; nothing new is
                // presented until the multiply completes.
                r_state     <= ST_BUSY;
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_zero      <= w_zero;
                r_carry     <= w_carry;
                r_ovf       <= w_ovf;
                r_err       <= w_err;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign err       = r_err;

endmodule : pipelined_alu
`default_nettype wire
